ps2_rx_frame: RTL
=================

Name: ps2_rx_frame

Overview:
- System-clock-domain PS/2 receive front end.
- Synchronises and deglitches the raw ps2_clk/ps2_data lines, then assembles 11-bit device-to-host frames.
- Checks start, odd parity and stop bits, and delivers each validated scan-code byte as a one-cycle strobe.
- Sits between the board PS/2 pins and ps2_keyboard's make/break decode, so that decode runs entirely on clk.

Parameters:
- FILTER_LEN, 8: consecutive clk samples of the synchronised ps2_clk that must disagree with the filtered level before the filtered level flips (range 2..255).
- TIMEOUT_CYCLES, 50000: clk cycles with no filtered falling edge, while mid-frame, before the frame is abandoned (1 ms at 50 MHz; 16-bit counter).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk
- ps2_data  in  1  raw PS/2 data pin, asynchronous to clk
- rx_byte  out  8  last valid received byte, LSB-first assembled
- rx_valid  out  1  one-cycle pulse; rx_byte updated in the same cycle
- rx_error  out  1  one-cycle pulse on any frame fault
- busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: synchronous active-high, effective on the next clk edge.
  - Sync flops reset to 1; filt_clk resets to 1; state to IDLE; counters to 0.
  - Outputs after reset: rx_byte=0, rx_valid=0, rx_error=0, busy=0.
  - Reset mid-frame drops the partial frame silently: no rx_error pulse.
- Synchroniser: two flops each on ps2_clk and ps2_data, giving s_clk and s_data.
- Filter:
  - Counter increments while s_clk != filt_clk and clears when they are equal.
  - When the counter reaches FILTER_LEN-1 with s_clk still != filt_clk, filt_clk flips and the counter clears.
  - A glitch shorter than FILTER_LEN cycles never reaches filt_clk.
- Edge detect: fall = filt_clk_q & ~filt_clk, registered one cycle. On fall, s_data is sampled as the bit value.
- State machine:
  - IDLE: on fall with bit=0 (start bit), go to DATA with bit_cnt=0. On fall with bit=1, stay in IDLE with no error.
  - DATA: on each fall, shift the bit in at [bit_cnt] (LSB first) and increment bit_cnt. After the 8th bit, go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP:
    - On fall, if stop=1 and the XOR of 8 data bits plus parity is 1 (odd parity): rx_byte <= shift, rx_valid=1 for one cycle.
    - Otherwise rx_error=1 for one cycle and rx_byte is unchanged.
    - Always return to IDLE.
- Timeout:
  - idle_cnt clears on every fall and in IDLE, and increments otherwise.
  - When idle_cnt reaches TIMEOUT_CYCLES-1 in a non-IDLE state: go to IDLE and pulse rx_error.
  - A fall in the same cycle wins: it clears the counter and is processed normally, with no timeout.
- Latency: rx_valid rises exactly FILTER_LEN+3 clk cycles after the raw ps2_clk falling edge of the stop bit, provided ps2_clk stays clean.
- rx_valid and rx_error are mutually exclusive and never high for more than one consecutive cycle.
- Back-to-back frames need no idle gap beyond the PS/2 protocol: a start-bit fall on the cycle after STOP completes is accepted.
- Bits sampled by s_data are stable because PS/2 data changes only while ps2_clk is high; no extra data filtering is applied.
- If ps2_clk is held low across reset release, the filter produces one fall. This is processed as a normal IDLE edge: start if data is 0, ignored otherwise.

Decomposition:
- ps2_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP)
  - frame constants: PS2_DATA_BITS=8, PS2_BREAK=8'hF0, PS2_EXT=8'hE0
  - the default FILTER_LEN and TIMEOUT_CYCLES
- Sub-module ps2_line_filter: 2-flop synchroniser plus FILTER_LEN glitch filter, single bit.
  - Instantiated for ps2_clk with filtering.
  - Its synchroniser-only path is used for ps2_data (bypass parameter).

Test Plan:
- Clean frame 0x1C (start 0, data LSB first, parity 0, stop 1) at a 12.5 kHz PS/2 clock -> one rx_valid with rx_byte=0x1C at exactly FILTER_LEN+3 cycles after the stop fall; rx_error stays 0.
- Frame 0xF0 followed immediately by 0x23 -> two rx_valid pulses with bytes 0xF0 then 0x23; busy drops between them for at least 1 cycle.
- Frame 0x29 with the parity bit flipped -> rx_error pulse, no rx_valid, rx_byte keeps its previous value. Repeat with stop=0 -> rx_error.
- 1-cycle and (FILTER_LEN-1)-cycle low glitches on ps2_clk during IDLE and mid-DATA -> no state change and no extra bits; the following clean frame 0x1C is received correctly.
- Frame stopped after 4 data bits -> rx_error pulse at TIMEOUT_CYCLES after the last fall and busy=0. A subsequent 0x23 frame is received correctly.
- Assert reset for 1 cycle mid-DATA -> next cycle shows busy=0, rx_byte=0, no rx_error. The following 0x1C frame yields rx_valid with 0x1C.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types and frame constants.
// Imported by the line filter, the frame receiver and the keyboard decode.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int          PS2_DATA_BITS      = 8;
  localparam logic [7:0]  PS2_BREAK          = 8'hF0;
  localparam logic [7:0]  PS2_EXT            = 8'hE0;
  localparam int          PS2_FILTER_LEN_DEF = 8;
  localparam int          PS2_TIMEOUT_DEF    = 50000;

  // Frame parity is odd: data bits plus parity bit must XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser for one PS/2 line, optionally followed by a
// persistence filter that only follows changes lasting FILTER_LEN samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8,
  parameter bit BYPASS     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level
);

  logic meta_r;
  logic sync_r;

  // Synchroniser; the bus idles high so reset to 1 avoids a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= line;
      sync_r <= meta_r;
    end
  end

  generate
    if (BYPASS) begin : g_bypass
      assign level = sync_r;
    end else begin : g_filter
      localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

      logic [7:0] cnt_r;
      logic       filt_r;

      // Flip the filtered level only after FILTER_LEN disagreeing samples in a row.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_r  <= 8'd0;
          filt_r <= 1'b1;
        end else if (sync_r != filt_r) begin
          if (cnt_r == CNT_LAST) begin
            cnt_r  <= 8'd0;
            filt_r <= sync_r;
          end else begin
            cnt_r  <= cnt_r + 8'd1;
          end
        end else begin
          cnt_r <= 8'd0;
        end
      end

      assign level = filt_r;
    end
  endgenerate

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: filters the pins, assembles 11-bit frames
// and emits each valid scan-code byte, or an error pulse, as a strobe.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       busy
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  BIT_LAST     = 3'(PS2_DATA_BITS - 1);

  logic       filt_clk_s;
  logic       data_s;
  logic       filt_q_r;
  logic       fall_s;

  ps2_state_e state_r,   state_nxt_s;
  logic [2:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0] shift_r,   shift_nxt_s;
  logic       parity_r,  parity_nxt_s;
  logic [15:0] idle_cnt_r, idle_cnt_nxt_s;
  logic [7:0] rx_byte_r, rx_byte_nxt_s;
  logic       rx_valid_r, rx_valid_nxt_s;
  logic       rx_error_r, rx_error_nxt_s;
  logic       busy_r;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .BYPASS(1'b0)) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .line  (ps2_clk),
    .level (filt_clk_s)
  );

  // Data only needs synchronising: it is stable whenever the clock falls.
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .BYPASS(1'b1)) u_data_sync (
    .clk   (clk),
    .reset (reset),
    .line  (ps2_data),
    .level (data_s)
  );

  assign fall_s = filt_q_r & ~filt_clk_s;

  // Frame state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q_r   <= 1'b1;
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
      parity_r   <= 1'b0;
      idle_cnt_r <= 16'd0;
      rx_byte_r  <= 8'd0;
      rx_valid_r <= 1'b0;
      rx_error_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      filt_q_r   <= filt_clk_s;
      state_r    <= state_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      parity_r   <= parity_nxt_s;
      idle_cnt_r <= idle_cnt_nxt_s;
      rx_byte_r  <= rx_byte_nxt_s;
      rx_valid_r <= rx_valid_nxt_s;
      rx_error_r <= rx_error_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
    end
  end

  // Next-state decode: frame sequencing, validation and inactivity timeout.
  always_comb begin
    state_nxt_s    = state_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    shift_nxt_s    = shift_r;
    parity_nxt_s   = parity_r;
    rx_byte_nxt_s  = rx_byte_r;
    rx_valid_nxt_s = 1'b0;
    rx_error_nxt_s = 1'b0;

    if ((state_r == ST_IDLE) || fall_s) begin
      idle_cnt_nxt_s = 16'd0;
    end else begin
      idle_cnt_nxt_s = idle_cnt_r + 16'd1;
    end

    case (state_r)
      ST_IDLE: begin
        if (fall_s && !data_s) begin
          state_nxt_s   = ST_DATA;
          bit_cnt_nxt_s = 3'd0;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          shift_nxt_s[bit_cnt_r] = data_s;
          bit_cnt_nxt_s          = bit_cnt_r + 3'd1;
          if (bit_cnt_r == BIT_LAST) begin
            state_nxt_s = ST_PARITY;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          parity_nxt_s = data_s;
          state_nxt_s  = ST_STOP;
        end else begin
          state_nxt_s  = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          state_nxt_s = ST_IDLE;
          if (data_s && odd_parity_ok(shift_r, parity_r)) begin
            rx_byte_nxt_s  = shift_r;
            rx_valid_nxt_s = 1'b1;
          end else begin
            rx_error_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // A fall arriving in the expiry cycle is served instead of timing out.
    if ((state_r != ST_IDLE) && !fall_s && (idle_cnt_r == TIMEOUT_LAST)) begin
      state_nxt_s    = ST_IDLE;
      rx_error_nxt_s = 1'b1;
    end else begin
      rx_error_nxt_s = rx_error_nxt_s;
    end
  end

  assign rx_byte  = rx_byte_r;
  assign rx_valid = rx_valid_r;
  assign rx_error = rx_error_r;
  assign busy     = busy_r;

endmodule
